// File: rtl/zigzag_quant.sv
// Buffers one 8x8 block of DCT coefficients arriving in raster order, then replays it in
// JPEG zigzag order after scaling each coefficient by a reciprocal quantizer step.
module zigzag_quant #(
  parameter int unsigned DW = 10,
  parameter int unsigned RW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [RW-1:0] q_recip,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  typedef enum logic {StFill, StDrain} state_e;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Sign-magnitude multiply so rounding is symmetric (half away from zero).
  function automatic logic [DW-1:0] quant(input logic [DW-1:0] c, input logic [RW-1:0] qr);
    logic [DW-1:0]    mag;
    logic [DW+RW-1:0] m;
    logic [DW-1:0]    r;
    mag = c[DW-1] ? -c : c;
    m   = {{RW{1'b0}}, mag} * {{DW{1'b0}}, qr};
    m   = m + ((DW+RW)'(1) << (RW-1));
    r   = m[DW+RW-1:RW];
    return c[DW-1] ? -r : r;
  endfunction

  state_e        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [5:0]    zcnt_q, zcnt_d;
  logic [5:0]    znext;
  logic [RW-1:0] qr_q, qr_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          wr_en;
  logic [DW-1:0] mem_q [64];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    zcnt_d      = zcnt_q;
    qr_d        = qr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    wr_en       = 1'b0;
    znext       = zcnt_q + 6'd1;
    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd0) qr_d = q_recip;
          if (cnt_q == 6'd63) begin
            // Raster 0 was written long ago, so beat 0 can be loaded on the last write.
            state_d     = StDrain;
            zcnt_d      = 6'd0;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            out_data_d  = quant(mem_q[ZZ[0]], qr_q);
          end
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (zcnt_q == 6'd63) begin
            state_d     = StFill;
            cnt_d       = 6'd0;
            zcnt_d      = 6'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            zcnt_d     = znext;
            out_data_d = quant(mem_q[ZZ[znext]], qr_q);
            out_last_d = (znext == 6'd63);
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StFill;
      cnt_q       <= 6'd0;
      zcnt_q      <= 6'd0;
      qr_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      zcnt_q      <= zcnt_d;
      qr_q        <= qr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[cnt_q] <= in_data;
  end

  assign in_ready  = (state_q == StFill);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_zigzag_quant.sv
// Scoreboard bench for zigzag_quant: the driver queues expected zigzag beats per frame and a
// negedge monitor pops and compares on every output handshake.
module tb_zigzag_quant;
  localparam int DW = 10;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [RW-1:0] q_recip = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;

  always #5 clk = ~clk;

  zigzag_quant #(.DW(DW), .RW(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .q_recip   (q_recip),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  int            n_cmp = 0;
  int            n_fail = 0;
  int            hs_cnt = 0;
  bit            bp = 1'b0;
  bit            stall_pend = 1'b0;
  bit            end_pend = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;
  logic [DW:0]   exp_q [$];
  int            zz [64];
  int            vals [64];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Zigzag built by walking anti-diagonals, independent of the RTL table.
  function automatic void build_zz();
    int z = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz[z] = r * 8 + (s - r); z++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz[z] = r * 8 + (s - r); z++; end
      end
    end
  endfunction

  function automatic int q_model(input int c, input int qr);
    longint a, r;
    a = (c < 0) ? -c : c;
    r = (a * qr + 32768) / 65536;
    return (c < 0) ? -int'(r) : int'(r);
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    logic [DW:0] e;
    if (end_pend) begin
      check("drain_end_out_valid", out_valid, 0);
      check("drain_end_in_ready", in_ready, 1);
      end_pend = 1'b0;
    end
    if (rst && out_valid) begin
      if (stall_pend) begin
        check("stall_data", $signed(out_data), $signed(held_data));
        check("stall_last", out_last, held_last);
      end
      if (out_ready) begin
        stall_pend = 1'b0;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0d, expected no output", $signed(out_data));
        end else begin
          e = exp_q.pop_front();
          check("beat_data", $signed(out_data), $signed(e[DW-1:0]));
          check("beat_last", out_last, e[DW]);
          if (e[DW]) end_pend = 1'b1;
        end
      end else begin
        stall_pend = 1'b1;
        held_data  = out_data;
        held_last  = out_last;
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic send_frame(input int qr, input int qr_junk, input int n_send, input bit gaps,
                            input bit garbage);
    int k = 0;
    int guard = 0;
    bit acc;
    logic [DW:0] e;
    while (k < n_send && guard < 2000) begin
      @(negedge clk);
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = DW'(vals[k]);
      q_recip  = (k == 0) ? RW'(qr) : RW'(qr_junk);
      acc      = in_valid && in_ready;
      if (acc && k == 63) check("no_valid_before_last_in", out_valid, 0);
      @(posedge clk);
      if (acc) k++;
      guard++;
    end
    if (k < n_send) begin
      n_cmp++;
      n_fail++;
      $display("FAIL fill_timeout: got %0d transfers, expected %0d", k, n_send);
    end
    if (n_send == 64) begin
      for (int z = 0; z < 64; z++) begin
        e[DW]     = (z == 63);
        e[DW-1:0] = DW'(q_model(vals[zz[z]], qr));
        exp_q.push_back(e);
      end
      @(negedge clk);
      check("first_valid_latency", out_valid, 1);
      in_valid = garbage;
      in_data  = DW'($urandom);
    end
  endtask

  task automatic wait_drain(input bit garbage);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      if (garbage && out_valid) check("drain_in_ready", in_ready, 0);
      in_valid = garbage && out_valid;
      in_data  = DW'($urandom);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_last", out_last, 0);
    check("reset_out_data", $signed(out_data), 0);
    rst = 1'b1;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 64; i++) vals[i] = v;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 64; i++) vals[i] = i;
  endtask

  initial begin
    int base;
    build_zz();
    repeat (2) @(posedge clk);
    pulse_reset();

    set_ramp();  send_frame(65535, 65535, 64, 0, 0); wait_drain(0);
    set_all(100);  send_frame(8192, 8192, 64, 0, 0); wait_drain(0);
    set_all(-100); send_frame(8192, 8192, 64, 1, 0); wait_drain(0);
    set_all(4);    send_frame(8192, 8192, 64, 0, 0); wait_drain(0);
    set_all(3);    send_frame(8192, 8192, 64, 0, 0); wait_drain(0);

    set_all(0); vals[0] = -512; vals[1] = 511;
    send_frame(65535, 65535, 64, 0, 0); wait_drain(0);

    for (int i = 0; i < 64; i++) vals[i] = int'($urandom_range(0, 1023)) - 512;
    send_frame(0, 65535, 64, 0, 0); wait_drain(0);

    // Reciprocal changes after index 0 must not touch the current frame.
    set_ramp(); send_frame(65535, 1000, 64, 1, 0); wait_drain(0);

    bp = 1'b1;
    set_ramp(); send_frame(65535, 65535, 64, 1, 0); wait_drain(0);
    bp = 1'b0;

    set_ramp(); send_frame(65535, 65535, 64, 0, 1); wait_drain(1);
    for (int i = 0; i < 64; i++) vals[i] = 63 - i;
    send_frame(65535, 65535, 64, 0, 0); wait_drain(0);

    set_all(77); send_frame(65535, 65535, 30, 0, 0);
    pulse_reset();
    set_ramp(); send_frame(65535, 65535, 64, 0, 0); wait_drain(0);

    set_ramp(); send_frame(65535, 65535, 64, 0, 0);
    base = hs_cnt;
    for (int g = 0; g < 200 && hs_cnt - base < 20; g++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    check("mid_drain_reset_beats", hs_cnt - base, 20);
    check("mid_drain_reset_out_valid", out_valid, 0);
    check("mid_drain_reset_in_ready", in_ready, 1);
    base = hs_cnt;
    repeat (10) @(posedge clk);
    check("no_beats_after_reset", hs_cnt - base, 0);

    set_all(-100); send_frame(8192, 8192, 64, 0, 0); wait_drain(0);
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
